// File: rtl/display_arbiter_pkg.sv
// Shared encodings and constants for the display arbiter and its BCD converter.
package display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_WRITE   = 2'd2
    } state_e;

    localparam int          OVF_LIMIT     = 10000;
    localparam logic [3:0]  BLANK_NIBBLE  = 4'hF;
    localparam int          DEF_NUM_WIDTH = 13;

    // Double-dabble correction applied before every shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: load captures the number, each step does one
// add-3/shift iteration; after W steps bcd_o holds four BCD digits.
module bin2bcd_seq
    import display_arbiter_pkg::*;
#(
    parameter int W = DEF_NUM_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] bin_i,
    output logic [15:0]  bcd_o
);

    logic [W-1:0] bin_q, bin_d;
    logic [15:0]  bcd_q, bcd_d;

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        if (load_i) begin
            bin_d = bin_i;
            bcd_d = '0;
        end else if (step_i) begin
            {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter that converts one requester's number to BCD and writes it to
// display slot A or B; FSM is IDLE -> CONVERT (NUM_WIDTH cycles) -> WRITE -> IDLE.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int NUM_REQ   = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*NUM_WIDTH-1:0] NumIn,
    input  logic [NUM_REQ-1:0]           Slot,
    output logic [NUM_REQ-1:0]           Grant,
    output logic                         Busy,
    output logic [15:0]                  DigitsA,
    output logic [15:0]                  DigitsB,
    output logic                         ValidA,
    output logic                         ValidB
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_WIDTH + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 slot_q, slot_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          digits_a_q, digits_a_d;
    logic [15:0]          digits_b_q, digits_b_d;
    logic                 valid_a_q, valid_a_d;
    logic                 valid_b_q, valid_b_d;

    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     cand;
    logic [NUM_WIDTH-1:0] win_num;
    logic                 win_ovf;
    logic                 conv_load;
    logic                 conv_step;
    logic [15:0]          conv_bcd;
    logic [15:0]          result;

    // Handshake: a requester holds Req high until it sees its one-cycle Grant pulse;
    // Req is only sampled in IDLE, so anything raised while Busy waits for IDLE.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && Req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_num = NumIn[i*NUM_WIDTH +: NUM_WIDTH];
            end
        end
        win_ovf = (32'(win_num) >= OVF_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = '0;
        slot_d     = slot_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        digits_a_d = digits_a_q;
        digits_b_d = digits_b_q;
        valid_a_d  = valid_a_q;
        valid_b_d  = valid_b_q;
        conv_load  = 1'b0;
        conv_step  = 1'b0;
        result     = ovf_q ? {4{BLANK_NIBBLE}} : conv_bcd;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                    slot_d          = Slot[winner];
                    ovf_d           = win_ovf;
                    cnt_d           = '0;
                    conv_load       = 1'b1;
                    state_d         = win_ovf ? ST_WRITE : ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                conv_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_WIDTH - 1)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (slot_q) begin
                    digits_b_d = result;
                    valid_b_d  = 1'b1;
                end else begin
                    digits_a_d = result;
                    valid_a_d  = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
            slot_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            digits_a_q <= {4{BLANK_NIBBLE}};
            digits_b_q <= {4{BLANK_NIBBLE}};
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            slot_q     <= slot_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            digits_a_q <= digits_a_d;
            digits_b_q <= digits_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
        end
    end

    bin2bcd_seq #(.W(NUM_WIDTH)) u_bin2bcd (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .load_i (conv_load),
        .step_i (conv_step),
        .bin_i  (win_num),
        .bcd_o  (conv_bcd)
    );

    assign Grant   = grant_q;
    assign Busy    = (state_q != ST_IDLE);
    assign DigitsA = digits_a_q;
    assign DigitsB = digits_b_q;
    assign ValidA  = valid_a_q;
    assign ValidB  = valid_b_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: a 13-bit instance for the main behaviour and a 14-bit
// instance so that 9999, 10000 and 12000 can be presented.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req_m, slot_m, grant_m;
    logic [51:0] num_m;
    logic        busy_m, va_m, vb_m;
    logic [15:0] da_m, db_m;

    logic [3:0]  req_w, slot_w, grant_w;
    logic [55:0] num_w;
    logic        busy_w, va_w, vb_w;
    logic [15:0] da_w, db_w;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    logic [15:0] mod_a [2];
    logic [15:0] mod_b [2];
    logic        mv_a  [2];
    logic        mv_b  [2];

    always #5 clk = ~clk;

    display_arbiter dut (
        .Clk(clk), .Rst(rst), .Req(req_m), .NumIn(num_m), .Slot(slot_m),
        .Grant(grant_m), .Busy(busy_m), .DigitsA(da_m), .DigitsB(db_m),
        .ValidA(va_m), .ValidB(vb_m)
    );

    display_arbiter #(.NUM_WIDTH(14)) dut_w (
        .Clk(clk), .Rst(rst), .Req(req_w), .NumIn(num_w), .Slot(slot_w),
        .Grant(grant_w), .Busy(busy_w), .DigitsA(da_w), .DigitsB(db_w),
        .ValidA(va_w), .ValidB(vb_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic logic [3:0] v_grant(input bit w); return w ? grant_w : grant_m; endfunction
    function automatic logic v_busy(input bit w); return w ? busy_w : busy_m; endfunction
    function automatic logic [15:0] v_da(input bit w); return w ? da_w : da_m; endfunction
    function automatic logic [15:0] v_db(input bit w); return w ? db_w : db_m; endfunction
    function automatic logic v_va(input bit w); return w ? va_w : va_m; endfunction
    function automatic logic v_vb(input bit w); return w ? vb_w : vb_m; endfunction

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            mod_a[i] = 16'hFFFF;
            mod_b[i] = 16'hFFFF;
            mv_a[i]  = 1'b0;
            mv_b[i]  = 1'b0;
        end
    endtask

    task automatic drive(input bit w, input int idx, input int num, input bit slt, input bit on);
        if (w) begin
            req_w[idx]           = on;
            num_w[idx*14 +: 14]  = 14'(num);
            slot_w[idx]          = slt;
        end else begin
            req_m[idx]           = on;
            num_m[idx*13 +: 13]  = 13'(num);
            slot_m[idx]          = slt;
        end
    endtask

    task automatic wait_grant(input bit w, output logic [3:0] g);
        int n;
        n = 0;
        g = v_grant(w);
        while (g == 4'd0 && n < 50) begin
            @(posedge clk); #1;
            g = v_grant(w);
            n++;
        end
    endtask

    task automatic pop_check(input bit w);
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (e[16]) begin
            check("digits_b", v_db(w), e[15:0]);
            check("valid_b", v_vb(w), 1);
            check("digits_a_kept", v_da(w), mod_a[w]);
            check("valid_a_kept", v_va(w), mv_a[w]);
            mod_b[w] = e[15:0];
            mv_b[w]  = 1'b1;
        end else begin
            check("digits_a", v_da(w), e[15:0]);
            check("valid_a", v_va(w), 1);
            check("digits_b_kept", v_db(w), mod_b[w]);
            check("valid_b_kept", v_vb(w), mv_b[w]);
            mod_a[w] = e[15:0];
            mv_a[w]  = 1'b1;
        end
    endtask

    // Called in the cycle after grant edge E; returns just after edge E+lat.
    task automatic finish_conv(input bit w, input int lat);
        int bad_g, bad_b;
        logic [16:0] e;
        bad_g = 0;
        bad_b = 0;
        e = exp_q[0];
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            if (v_grant(w) != 4'd0) bad_g++;
            if (!v_busy(w)) bad_b++;
        end
        if (lat > 1) begin
            check("grant_quiet", 32'(bad_g), 0);
            check("busy_hold", 32'(bad_b), 0);
            check("digits_not_early", e[16] ? v_db(w) : v_da(w), e[16] ? mod_b[w] : mod_a[w]);
        end
        @(posedge clk); #1;
        pop_check(w);
        check("busy_done", v_busy(w), 0);
    endtask

    task automatic send(input bit w, input int idx, input int num, input bit slt);
        logic [3:0] g;
        int lat;
        lat = (num >= 10000) ? 1 : (w ? 15 : 14);
        exp_q.push_back({slt, (num >= 10000) ? 16'hFFFF : to_bcd(num)});
        drive(w, idx, num, slt, 1'b1);
        wait_grant(w, g);
        check("grant", g, 32'(1 << idx));
        check("busy_on_grant", v_busy(w), 1);
        drive(w, idx, num, slt, 1'b0);
        finish_conv(w, lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        int bad_g, ng, gi;
        int gidx [5];
        int gtime[5];

        rst = 1'b1;
        req_m = '0; slot_m = '0; num_m = '0;
        req_w = '0; slot_w = '0; num_w = '0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_grant", grant_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_digits_a", da_m, 16'hFFFF);
        check("rst_digits_b", db_m, 16'hFFFF);
        check("rst_valid_a", va_m, 0);
        check("rst_valid_b", vb_m, 0);

        // Single request, then boundary values that fit 13 bits.
        send(0, 0, 1234, 0);
        send(0, 1, 0, 1);
        send(0, 2, 8191, 0);
        send(0, 3, $urandom_range(8191), 1);

        // Values that need 14 bits: 9999 converts, 10000/12000 take the overflow path.
        send(1, 0, 9999, 0);
        send(1, 1, 10000, 0);
        send(1, 2, 12000, 1);

        // Request raised during a conversion waits for IDLE.
        exp_q.push_back({1'b0, to_bcd(1234)});
        exp_q.push_back({1'b1, to_bcd(777)});
        drive(0, 0, 1234, 0, 1'b1);
        wait_grant(0, g);
        check("busy_req0_grant", g, 4'b0001);
        drive(0, 0, 1234, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1, 777, 1, 1'b1);
        bad_g = 0;
        for (int k = 3; k < 14; k++) begin
            @(posedge clk); #1;
            if (grant_m != 4'd0) bad_g++;
        end
        check("busy_no_grant", 32'(bad_g), 0);
        @(posedge clk); #1;
        pop_check(0);
        check("busy_idle_no_grant", grant_m, 0);
        @(posedge clk); #1;
        check("busy_req1_grant", grant_m, 4'b0010);
        drive(0, 1, 777, 1, 1'b0);
        finish_conv(0, 14);

        // Reset in the middle of a conversion of 4321.
        drive(0, 0, 4321, 0, 1'b1);
        wait_grant(0, g);
        check("abort_grant", g, 4'b0001);
        drive(0, 0, 4321, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        req_m[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_m[1] = 1'b0;
        reset_models();
        check("abort_busy", busy_m, 0);
        check("abort_grant_in_rst", grant_m, 0);
        check("abort_digits_a", da_m, 16'hFFFF);
        check("abort_valid_a", va_m, 0);
        repeat (16) @(posedge clk);
        #1;
        check("abort_no_late_a", da_m, 16'hFFFF);
        check("abort_no_late_va", va_m, 0);
        send(0, 0, 4321, 0);

        // Round-robin with all requesters asserted, starting from reset priority.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_models();
        for (int i = 0; i < 4; i++) drive(0, i, 100 * (i + 1), i[0], 1'b1);
        ng = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(posedge clk); #1;
            if (grant_m != 4'd0 && ng < 5) begin
                gi = -1;
                for (int i = 0; i < 4; i++) if (grant_m[i]) gi = i;
                gidx[ng]  = gi;
                gtime[ng] = cyc;
                ng++;
            end
        end
        req_m = '0;
        check("rr_count", 32'(ng), 5);
        for (int i = 0; i < ng; i++) begin
            check("rr_order", 32'(gidx[i]), 32'(i % 4));
            if (i > 0) check("rr_gap", 32'(gtime[i] - gtime[i-1]), 15);
        end
        repeat (20) @(posedge clk);
        #1;

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter NUM_WIDTH, default 13, sets the binary width of each requester number.
REQ-002 Parameter NUM_REQ, default 4, sets the number of requesters.
REQ-003 Clk  input  1  system clock (100 MHz); all state changes on the rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 Req  input  NUM_REQ  per-requester display-write request, level.
REQ-006 NumIn  input  NUM_REQ*NUM_WIDTH  packed numbers; requester i occupies bits [i*NUM_WIDTH +: NUM_WIDTH].
REQ-007 Slot  input  NUM_REQ  per-requester target; 0 = display A, 1 = display B.
REQ-008 Grant  output  NUM_REQ  one-hot grant pulse.
REQ-009 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 DigitsA  output  16  BCD digits for display A, thousands in [15:12], ones in [3:0].
REQ-011 DigitsB  output  16  BCD digits for display B, same layout as DigitsA.
REQ-012 ValidA, ValidB  output  1 each  high once the slot has been written since reset.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONVERT and WRITE.
REQ-014 IDLE, any Req bit high at edge E: pick the winner round-robin, starting at index last_grant+1 mod NUM_REQ.
- At the same edge E, capture the winner's NumIn slice and Slot bit.
- Next state is CONVERT, or WRITE if the overflow rule (REQ-018) applies.
REQ-015 Grant[winner] SHALL be high for exactly the one cycle following edge E; Grant SHALL be 0 at all other times.
REQ-016 Req bits SHALL be ignored while Busy=1. A requester holds Req until it sees Grant. A Req withdrawn before grant is not serviced.
REQ-017 CONVERT SHALL perform iterative double-dabble, one shift per cycle, for exactly NUM_WIDTH cycles (13).
- Before each shift, add 3 to every BCD nibble that is >= 5.
- After the last shift, go to WRITE.
REQ-018 A captured number >= 10000 SHALL skip CONVERT; the result SHALL be 16'hFFFF (all nibbles 4'hF).
REQ-019 WRITE SHALL last one cycle, then return to IDLE.
- At the edge leaving WRITE, load the result into DigitsA (Slot=0) or DigitsB (Slot=1).
- At the same edge, set the matching Valid flag.
- The other slot's digits and Valid flag SHALL be unchanged.
REQ-020 Latency: digits SHALL update at edge E+14 for a normal conversion and at edge E+1 for overflow.
REQ-021 Throughput: a new grant SHALL be possible at the first edge where the FSM is in IDLE, i.e. back-to-back with no gap cycle.
REQ-022 last_grant SHALL update only when a grant is issued. Pointer wrap: after a grant to index NUM_REQ-1, index 0 has first priority.
REQ-023 Boundary values:
- 0 SHALL yield 16'h0000.
- 9999 SHALL yield 16'h9999.
- 10000 SHALL yield 16'hFFFF.
- The maximum input 8191 (13-bit) SHALL yield 16'h8191.

Reset
REQ-024 When Rst=1 at an edge, the block SHALL enter IDLE, including mid-CONVERT or mid-WRITE. The aborted request SHALL be dropped with no output update.
REQ-025 Reset values SHALL be:
- Grant = 0 and Busy = 0.
- DigitsA = DigitsB = 16'hFFFF.
- ValidA = ValidB = 0.
- last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-026 Req SHALL be ignored on any edge where Rst=1.

Structure
REQ-027 A shared package SHALL hold:
- the state encodings IDLE/CONVERT/WRITE;
- OVF_LIMIT = 10000;
- BLANK_NIBBLE = 4'hF;
- the default NUM_WIDTH = 13.
REQ-028 The double-dabble shift/add datapath SHALL be one sub-module, bin2bcd_seq, with load, step and a 16-bit BCD result; the FSM and arbiter stay in display_arbiter.
REQ-029 DigitsA and DigitsB SHALL connect directly to the existing two-4-digit display driver's digit inputs; display_arbiter SHALL not drive segments or anodes.

Verification
REQ-030 Single request:
- Stimulus: Req=4'b0001, NumIn[12:0]=1234, Slot[0]=0.
- Response: Grant=4'b0001 for one cycle; DigitsA=16'h1234 and ValidA=1 at E+14; DigitsB=16'hFFFF and ValidB=0.
REQ-031 Overflow:
- Stimulus: requester 2, Num=12000, Slot[2]=1.
- Response: DigitsB=16'hFFFF, ValidB=1 at E+1; no CONVERT cycles (Busy high for 1 cycle only).
REQ-032 Round-robin:
- Stimulus: Req=4'b1111 held, each requester deasserting after its grant and reasserting immediately.
- Response: grants in order 0,1,2,3,0; consecutive grants exactly 15 cycles apart.
REQ-033 Boundaries:
- Stimulus: sequential requests with 0, 9999, 8191, 10000.
- Response: 16'h0000, 16'h9999, 16'h8191, 16'hFFFF.
REQ-034 Reset abort:
- Stimulus: Rst=1 at E+6 of a conversion of 4321.
- Response: Busy=0 next cycle; DigitsA=16'hFFFF, ValidA=0; a new request for 4321 completes normally.
REQ-035 Request during Busy:
- Stimulus: Req[1] asserted at E+3 while requester 0 converts.
- Response: Grant[1] on the first cycle after IDLE is re-entered; no Grant during Busy.
